// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline control: PC register, IF/ID and ID/EX pipeline registers,
// and saturating stall/flush event counters. All outputs come straight from flops.
module pipe_front_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_sleep,
    input  logic        IF_ID_sleep,
    input  logic        ID_Ex_flush,
    input  logic        Br_taken,
    input  logic [31:0] Br_target,
    input  logic [31:0] IF_Instr,
    input  logic        ID_RegWr,
    input  logic        ID_MemRead,
    input  logic        ID_MemWr,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_Rw,
    output logic [31:0] PC,
    output logic [31:0] ID_Instr,
    output logic [31:0] ID_PC4,
    output logic        ID_valid,
    output logic        Ex_RegWr,
    output logic        Ex_MemRead,
    output logic        Ex_MemWr,
    output logic [4:0]  Ex_Rs,
    output logic [4:0]  Ex_Rt,
    output logic [4:0]  Ex_Rw,
    output logic        Ex_valid,
    output logic [15:0] Stall_cnt,
    output logic [15:0] Flush_cnt
);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] id_instr_q, id_instr_d, id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        ex_regwr_q, ex_regwr_d, ex_memrd_q, ex_memrd_d, ex_memwr_q, ex_memwr_d;
    logic [4:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rw_q, ex_rw_d;
    logic        ex_valid_q, ex_valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_plus4;
        id_instr_d  = IF_Instr;
        id_pc4_d    = pc_plus4;
        id_valid_d  = 1'b1;
        ex_regwr_d  = ID_RegWr   & id_valid_q;
        ex_memrd_d  = ID_MemRead & id_valid_q;
        ex_memwr_d  = ID_MemWr   & id_valid_q;
        ex_rs_d     = ID_Rs;
        ex_rt_d     = ID_Rt;
        ex_rw_d     = ID_Rw;
        ex_valid_d  = id_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // A taken branch squashes everything younger, so it beats every hold.
        if (Br_taken)
            pc_d = Br_target;
        else if (PC_sleep)
            pc_d = pc_q;

        if (Br_taken) begin
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
        end else if (IF_ID_sleep) begin
            id_instr_d = id_instr_q;
            id_pc4_d   = id_pc4_q;
            id_valid_d = id_valid_q;
        end

        if (Br_taken || ID_Ex_flush) begin
            ex_regwr_d = 1'b0;
            ex_memrd_d = 1'b0;
            ex_memwr_d = 1'b0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_rw_d    = '0;
            ex_valid_d = 1'b0;
        end

        if (PC_sleep && !Br_taken && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (Br_taken && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            id_instr_q  <= '0;
            id_pc4_q    <= '0;
            id_valid_q  <= 1'b0;
            ex_regwr_q  <= 1'b0;
            ex_memrd_q  <= 1'b0;
            ex_memwr_q  <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rw_q     <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_instr_q  <= id_instr_d;
            id_pc4_q    <= id_pc4_d;
            id_valid_q  <= id_valid_d;
            ex_regwr_q  <= ex_regwr_d;
            ex_memrd_q  <= ex_memrd_d;
            ex_memwr_q  <= ex_memwr_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_rw_q     <= ex_rw_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC         = pc_q;
    assign ID_Instr   = id_instr_q;
    assign ID_PC4     = id_pc4_q;
    assign ID_valid   = id_valid_q;
    assign Ex_RegWr   = ex_regwr_q;
    assign Ex_MemRead = ex_memrd_q;
    assign Ex_MemWr   = ex_memwr_q;
    assign Ex_Rs      = ex_rs_q;
    assign Ex_Rt      = ex_rt_q;
    assign Ex_Rw      = ex_rw_q;
    assign Ex_valid   = ex_valid_q;
    assign Stall_cnt  = stall_cnt_q;
    assign Flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed-vector bench for pipe_front_ctrl: a table of per-edge stimulus with
// hand-computed post-edge state, plus stall-latency and counter-saturation sequences.
module tb_pipe_front_ctrl;

    typedef struct packed {
        logic        rst, ps, is, fl, br;
        logic [31:0] tgt, instr;
        logic        wr, mr, mw;
        logic [4:0]  rs, rt, rw;
    } in_t;

    typedef struct packed {
        logic [31:0] pc, id_instr, id_pc4;
        logic        id_valid, wr, mr, mw;
        logic [4:0]  rs, rt, rw;
        logic        ex_valid;
        logic [15:0] sc, fc;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, PC_sleep, IF_ID_sleep, ID_Ex_flush, Br_taken;
    logic [31:0] Br_target, IF_Instr;
    logic        ID_RegWr, ID_MemRead, ID_MemWr;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rw;
    logic [31:0] PC, ID_Instr, ID_PC4;
    logic        ID_valid, Ex_RegWr, Ex_MemRead, Ex_MemWr, Ex_valid;
    logic [4:0]  Ex_Rs, Ex_Rt, Ex_Rw;
    logic [15:0] Stall_cnt, Flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_front_ctrl dut (
        .clk(clk), .rst(rst), .PC_sleep(PC_sleep), .IF_ID_sleep(IF_ID_sleep),
        .ID_Ex_flush(ID_Ex_flush), .Br_taken(Br_taken), .Br_target(Br_target),
        .IF_Instr(IF_Instr), .ID_RegWr(ID_RegWr), .ID_MemRead(ID_MemRead),
        .ID_MemWr(ID_MemWr), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rw(ID_Rw),
        .PC(PC), .ID_Instr(ID_Instr), .ID_PC4(ID_PC4), .ID_valid(ID_valid),
        .Ex_RegWr(Ex_RegWr), .Ex_MemRead(Ex_MemRead), .Ex_MemWr(Ex_MemWr),
        .Ex_Rs(Ex_Rs), .Ex_Rt(Ex_Rt), .Ex_Rw(Ex_Rw), .Ex_valid(Ex_valid),
        .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mi(input logic r, input logic ps, input logic is, input logic fl,
                               input logic br, input logic [31:0] tgt, input logic [31:0] ins,
                               input logic wr, input logic mr, input logic mw,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw);
        in_t v;
        v = '{rst:r, ps:ps, is:is, fl:fl, br:br, tgt:tgt, instr:ins,
              wr:wr, mr:mr, mw:mw, rs:rs, rt:rt, rw:rw};
        return v;
    endfunction

    function automatic out_t mo(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4,
                                input logic iv, input logic wr, input logic mr, input logic mw,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                                input logic ev, input logic [15:0] sc, input logic [15:0] fc);
        out_t v;
        v = '{pc:pc, id_instr:ins, id_pc4:p4, id_valid:iv, wr:wr, mr:mr, mw:mw,
              rs:rs, rt:rt, rw:rw, ex_valid:ev, sc:sc, fc:fc};
        return v;
    endfunction

    function automatic out_t sample();
        return mo(PC, ID_Instr, ID_PC4, ID_valid, Ex_RegWr, Ex_MemRead, Ex_MemWr,
                  Ex_Rs, Ex_Rt, Ex_Rw, Ex_valid, Stall_cnt, Flush_cnt);
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst; PC_sleep = v.ps; IF_ID_sleep = v.is; ID_Ex_flush = v.fl;
        Br_taken = v.br; Br_target = v.tgt; IF_Instr = v.instr;
        ID_RegWr = v.wr; ID_MemRead = v.mr; ID_MemWr = v.mw;
        ID_Rs = v.rs; ID_Rt = v.rt; ID_Rw = v.rw;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    vec_t tbl[16];

    initial begin
        // Post-edge state is written out by hand for every row.
        tbl[0]  = '{mi(1,0,0,0,0,0,32'hA1,1,0,0,1,2,3),       mo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
        tbl[1]  = '{mi(0,0,0,0,0,0,32'hA1,1,0,0,1,2,3),       mo(4,32'hA1,4,1,0,0,0,1,2,3,0,0,0)};
        tbl[2]  = '{mi(0,0,0,0,0,0,32'hA2,1,1,0,4,5,6),       mo(8,32'hA2,8,1,1,1,0,4,5,6,1,0,0)};
        tbl[3]  = '{mi(0,0,0,0,0,0,32'hA3,0,0,1,7,8,9),       mo(12,32'hA3,12,1,0,0,1,7,8,9,1,0,0)};
        tbl[4]  = '{mi(0,0,0,0,0,0,32'hA4,1,0,0,1,2,3),       mo(16,32'hA4,16,1,1,0,0,1,2,3,1,0,0)};
        tbl[5]  = '{mi(0,1,1,1,0,0,32'hA5,1,0,0,10,11,12),    mo(16,32'hA4,16,1,0,0,0,0,0,0,0,1,0)};
        tbl[6]  = '{mi(0,0,0,0,0,0,32'hA5,1,0,0,10,11,12),    mo(20,32'hA5,20,1,1,0,0,10,11,12,1,1,0)};
        tbl[7]  = '{mi(0,1,1,0,1,32'h100,32'hA6,1,0,0,1,2,3), mo(32'h100,0,0,0,0,0,0,0,0,0,0,1,1)};
        tbl[8]  = '{mi(0,0,0,0,0,0,32'hA7,1,1,1,13,14,15),    mo(32'h104,32'hA7,32'h104,1,0,0,0,13,14,15,0,1,1)};
        tbl[9]  = '{mi(0,1,0,0,0,0,32'hA8,1,0,0,1,2,3),       mo(32'h104,32'hA8,32'h108,1,1,0,0,1,2,3,1,2,1)};
        tbl[10] = '{mi(0,0,1,0,0,0,32'hA9,0,1,0,4,5,6),       mo(32'h108,32'hA8,32'h108,1,0,1,0,4,5,6,1,2,1)};
        tbl[11] = '{mi(0,0,0,1,0,0,32'hAA,1,0,0,7,8,9),       mo(32'h10C,32'hAA,32'h10C,1,0,0,0,0,0,0,0,2,1)};
        tbl[12] = '{mi(0,0,0,0,1,32'hFFFFFFFC,32'hAB,1,0,0,1,2,3), mo(32'hFFFFFFFC,0,0,0,0,0,0,0,0,0,0,2,2)};
        tbl[13] = '{mi(0,0,0,0,0,0,32'hAC,1,0,0,1,2,3),       mo(0,32'hAC,0,1,0,0,0,1,2,3,0,2,2)};
        tbl[14] = '{mi(1,1,1,1,1,32'h200,32'hAD,1,1,1,1,2,3), mo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
        tbl[15] = '{mi(0,0,0,0,0,0,32'hAD,1,0,0,1,2,3),       mo(4,32'hAD,4,1,0,0,0,1,2,3,0,0,0)};

        drive(tbl[0].i);
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].i);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", k), tbl[k].o);
        end

        // Three-cycle full stall: PC/IF-ID frozen, ID/EX carries three bubbles.
        drive(mi(0,1,1,1,0,0,32'hAE,1,1,1,1,2,3));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_out($sformatf("stall%0d", k),
                      mo(4,32'hAD,4,1,0,0,0,0,0,0,0,16'(k+1),0));
        end

        // Counter saturation with PC held throughout.
        drive(mi(0,1,0,0,0,0,32'hAF,0,0,0,0,0,0));
        repeat (65540) @(posedge clk);
        #1;
        check32("stall_sat", {16'h0, Stall_cnt}, 32'h0000FFFF);
        check32("pc_hold_sat", PC, 32'h4);
        @(posedge clk); #1;
        check32("stall_sat_stays", {16'h0, Stall_cnt}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
